// File: rtl/wbuconsole_host_if.sv
// Signal bundle for the host-side debug-bus / console byte link.
// Handshake on every stream: a byte transfers on a cycle where stb && !busy;
// the source holds stb and data stable until that transfer happens.
// tx_dbg_* / tx_con_* : bytes from the bridge to be merged onto the UART TX.
// tx_*                : merged 8-bit UART TX stream (bit 7 = 1 for debug bus).
// rx_*                : incoming UART RX byte strobe (no backpressure).
// rx_dbg_* / rx_con_* : demultiplexed, buffered 7-bit RX streams.
interface wbuconsole_host_if;
  logic       tx_dbg_stb;
  logic [6:0] tx_dbg_data;
  logic       tx_dbg_busy;
  logic       tx_con_stb;
  logic [6:0] tx_con_data;
  logic       tx_con_busy;
  logic       tx_stb;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_stb;
  logic [7:0] rx_data;
  logic       rx_dbg_stb;
  logic [6:0] rx_dbg_data;
  logic       rx_dbg_busy;
  logic       rx_con_stb;
  logic [6:0] rx_con_data;
  logic       rx_con_busy;
  logic       dbg_ovfl;
  logic       con_ovfl;

  // Design-side view.
  modport slave (
    input  tx_dbg_stb, tx_dbg_data, tx_con_stb, tx_con_data, tx_busy,
           rx_stb, rx_data, rx_dbg_busy, rx_con_busy,
    output tx_dbg_busy, tx_con_busy, tx_stb, tx_data,
           rx_dbg_stb, rx_dbg_data, rx_con_stb, rx_con_data,
           dbg_ovfl, con_ovfl
  );

  // Environment-side view (UART, bridge logic).
  modport master (
    output tx_dbg_stb, tx_dbg_data, tx_con_stb, tx_con_data, tx_busy,
           rx_stb, rx_data, rx_dbg_busy, rx_con_busy,
    input  tx_dbg_busy, tx_con_busy, tx_stb, tx_data,
           rx_dbg_stb, rx_dbg_data, rx_con_stb, rx_con_data,
           dbg_ovfl, con_ovfl
  );
endinterface

// File: rtl/wbuconsole_host.sv
// Host/bridge end of the multiplexed debug-bus + console byte link.
// TX: round-robin merge of two 7-bit streams into one tagged 8-bit stream
// through a single holding register (bit 7: 1 = debug bus, 0 = console).
// RX: split incoming bytes by bit 7 into two buffered 7-bit streams.
// Optional: WBUCONSOLE_HOST_WAKEUP_EN sends WAKEUP_BYTE once after reset so
// the device command port turns on.

// Small FIFO with pointers one bit wider than the address; sticky overflow.
module wbuconsole_host_fifo #(
  parameter int LG = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [6:0] push_data,
  output logic       stb,
  output logic [6:0] data,
  input  logic       busy,
  output logic       ovfl
);
  localparam int DEPTH = 1 << LG;

  logic [6:0]  mem [DEPTH];
  logic [LG:0] wr_ptr;
  logic [LG:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LG] != rd_ptr[LG]) &&
                 (wr_ptr[LG-1:0] == rd_ptr[LG-1:0]);
  assign pop   = !empty && !busy;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign wr_en = push && (!full || pop);

  assign stb  = !empty;
  assign data = mem[rd_ptr[LG-1:0]];

  // Pointer and overflow-flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovfl   <= 1'b0;
    end else begin
      if (wr_en)         wr_ptr <= wr_ptr + 1'b1;
      if (pop)           rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) ovfl  <= 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[LG-1:0]] <= push_data;
  end
endmodule

module wbuconsole_host #(
  parameter int         LGFIFO      = 4,
  parameter logic [7:0] WAKEUP_BYTE = 8'h8A
) (
  input  logic                i_clk,
  input  logic                i_reset,
  wbuconsole_host_if.slave    bus
);
  logic       full;
  logic [7:0] hold;
  logic       last_dbg;     // 1 when the last grant went to the debug bus
  logic       wake_pending;
  logic       grant_dbg;
  logic       grant_con;

`ifdef WBUCONSOLE_HOST_WAKEUP_EN
  logic sent;

  // Sent flag: low only on the first cycle after reset, which is exactly the
  // cycle the wakeup byte loads (the holding register is empty then).
  always_ff @(posedge i_clk) begin
    if (i_reset) sent <= 1'b0;
    else         sent <= 1'b1;
  end

  assign wake_pending = !sent;
`else
  assign wake_pending = 1'b0;
`endif

  // A tie goes to whichever source did not win last time.
  assign bus.tx_dbg_busy = full || wake_pending || (bus.tx_con_stb && last_dbg);
  assign bus.tx_con_busy = full || wake_pending || (bus.tx_dbg_stb && !last_dbg);
  assign grant_dbg = bus.tx_dbg_stb && !bus.tx_dbg_busy;
  assign grant_con = bus.tx_con_stb && !bus.tx_con_busy;

  assign bus.tx_stb  = full;
  assign bus.tx_data = hold;

  // Holding register: drain takes a whole cycle, so no reload while full.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      full     <= 1'b0;
      last_dbg <= 1'b0;
    end else if (full) begin
      if (!bus.tx_busy) full <= 1'b0;
    end else if (wake_pending) begin
      full <= 1'b1;
      hold <= WAKEUP_BYTE;
    end else if (grant_dbg) begin
      full     <= 1'b1;
      hold     <= {1'b1, bus.tx_dbg_data};
      last_dbg <= 1'b1;
    end else if (grant_con) begin
      full     <= 1'b1;
      hold     <= {1'b0, bus.tx_con_data};
      last_dbg <= 1'b0;
    end
  end

  wbuconsole_host_fifo #(.LG(LGFIFO)) dbg_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (bus.rx_stb && bus.rx_data[7]),
    .push_data (bus.rx_data[6:0]),
    .stb       (bus.rx_dbg_stb),
    .data      (bus.rx_dbg_data),
    .busy      (bus.rx_dbg_busy),
    .ovfl      (bus.dbg_ovfl)
  );

  wbuconsole_host_fifo #(.LG(LGFIFO)) con_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (bus.rx_stb && !bus.rx_data[7]),
    .push_data (bus.rx_data[6:0]),
    .stb       (bus.rx_con_stb),
    .data      (bus.rx_con_data),
    .busy      (bus.rx_con_busy),
    .ovfl      (bus.con_ovfl)
  );
endmodule

// File: tb/tb_wbuconsole_host.sv
// Bench for wbuconsole_host: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_wbuconsole_host;
  localparam int DEPTH = 16;
`ifdef WBUCONSOLE_HOST_WAKEUP_EN
  localparam bit WAKE = 1'b1;
`else
  localparam bit WAKE = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wbuconsole_host_if bus();

  wbuconsole_host #(.LGFIFO(4), .WAKEUP_BYTE(8'h8A)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: holding register as a 0/1-entry queue, FIFOs as queues.
  logic [7:0] m_tx_q[$];
  logic [6:0] m_dbg_q[$];
  logic [6:0] m_con_q[$];
  bit m_last_dbg, m_wake_sent, m_dbg_ovfl, m_con_ovfl;
  bit model_valid = 1'b0;

  // Observed transfers, for literal checks in the directed tests.
  logic [7:0] tx_log[$];
  logic [6:0] dbg_log[$];
  logic [6:0] con_log[$];
  bit dbg_acc, con_acc;

  // Compare outputs to the model, log transfers, then advance the model.
  always @(negedge clk) begin : cmp
    bit mfull, wake_pend, gd, gc, dpop, cpop;
    mfull = (m_tx_q.size() != 0);
    wake_pend = WAKE && !m_wake_sent;
    if (model_valid) begin
      check("tx_stb", bus.tx_stb, mfull);
      if (mfull) check("tx_data", bus.tx_data, m_tx_q[0]);
      check("dbg_busy", bus.tx_dbg_busy, mfull || wake_pend || (bus.tx_con_stb && m_last_dbg));
      check("con_busy", bus.tx_con_busy, mfull || wake_pend || (bus.tx_dbg_stb && !m_last_dbg));
      check("rx_dbg_stb", bus.rx_dbg_stb, m_dbg_q.size() != 0);
      if (m_dbg_q.size() != 0) check("rx_dbg_data", bus.rx_dbg_data, m_dbg_q[0]);
      check("rx_con_stb", bus.rx_con_stb, m_con_q.size() != 0);
      if (m_con_q.size() != 0) check("rx_con_data", bus.rx_con_data, m_con_q[0]);
      check("dbg_ovfl", bus.dbg_ovfl, m_dbg_ovfl);
      check("con_ovfl", bus.con_ovfl, m_con_ovfl);
    end

    dbg_acc = bus.tx_dbg_stb && !bus.tx_dbg_busy;
    con_acc = bus.tx_con_stb && !bus.tx_con_busy;
    if (!reset) begin
      if (bus.tx_stb && !bus.tx_busy) tx_log.push_back(bus.tx_data);
      if (bus.rx_dbg_stb && !bus.rx_dbg_busy) dbg_log.push_back(bus.rx_dbg_data);
      if (bus.rx_con_stb && !bus.rx_con_busy) con_log.push_back(bus.rx_con_data);
    end

    if (reset) begin
      m_tx_q.delete(); m_dbg_q.delete(); m_con_q.delete();
      m_last_dbg = 1'b0; m_wake_sent = 1'b0;
      m_dbg_ovfl = 1'b0; m_con_ovfl = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (mfull) begin
        if (!bus.tx_busy) void'(m_tx_q.pop_front());
      end else if (wake_pend) begin
        m_tx_q.push_back(8'h8A);
        m_wake_sent = 1'b1;
      end else begin
        gd = bus.tx_dbg_stb && (!bus.tx_con_stb || !m_last_dbg);
        gc = bus.tx_con_stb && !gd;
        if (gd) begin m_tx_q.push_back({1'b1, bus.tx_dbg_data}); m_last_dbg = 1'b1; end
        else if (gc) begin m_tx_q.push_back({1'b0, bus.tx_con_data}); m_last_dbg = 1'b0; end
      end
      dpop = (m_dbg_q.size() != 0) && !bus.rx_dbg_busy;
      cpop = (m_con_q.size() != 0) && !bus.rx_con_busy;
      if (dpop) void'(m_dbg_q.pop_front());
      if (cpop) void'(m_con_q.pop_front());
      if (bus.rx_stb) begin
        if (bus.rx_data[7]) begin
          if (m_dbg_q.size() == DEPTH) m_dbg_ovfl = 1'b1;
          else m_dbg_q.push_back(bus.rx_data[6:0]);
        end else begin
          if (m_con_q.size() == DEPTH) m_con_ovfl = 1'b1;
          else m_con_q.push_back(bus.rx_data[6:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_dbg(input logic [6:0] d);
    int n;
    bus.tx_dbg_data = d;
    bus.tx_dbg_stb = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!dbg_acc && n < 50);
    check("dbg_accept", dbg_acc, 1'b1);
    bus.tx_dbg_stb = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_stb = 1'b1;
    bus.rx_data = b;
    tick();
    bus.rx_stb = 1'b0;
  endtask

  initial begin
    int off;
    bus.tx_dbg_stb = 0; bus.tx_dbg_data = 0; bus.tx_con_stb = 0; bus.tx_con_data = 0;
    bus.tx_busy = 0; bus.rx_stb = 0; bus.rx_data = 0;
    bus.rx_dbg_busy = 0; bus.rx_con_busy = 0;
    off = WAKE ? 1 : 0;

    // Reset state
    do_reset();
    check("reset_tx_stb", bus.tx_stb, 1'b0);
    check("reset_rx_dbg_stb", bus.rx_dbg_stb, 1'b0);
    check("reset_rx_con_stb", bus.rx_con_stb, 1'b0);
    check("reset_ovfl", {bus.dbg_ovfl, bus.con_ovfl}, 2'b00);

    // Single debug byte 7'h35 -> 8'hB5, one cycle latency, then drop
    tx_log.delete();
    send_dbg(7'h35);
    check("t1_stb_latency", bus.tx_stb, 1'b1);
    check("t1_data", bus.tx_data, 8'hB5);
    tick();
    check("t1_stb_drop", bus.tx_stb, 1'b0);
    tick(); tick();
    check("t1_log_size", tx_log.size(), off + 1);
    if (tx_log.size() >= 1) check("t1_first_byte", tx_log[0], WAKE ? 8'h8A : 8'hB5);

    // Both sources held high after reset: debug, console, debug, console
    do_reset();
    tx_log.delete();
    bus.tx_dbg_data = 7'h11; bus.tx_con_data = 7'h22;
    bus.tx_dbg_stb = 1'b1; bus.tx_con_stb = 1'b1;
    repeat (10) tick();
    bus.tx_dbg_stb = 1'b0; bus.tx_con_stb = 1'b0;
    repeat (3) tick();
    check("t2_log_size_ok", tx_log.size() >= off + 4, 1'b1);
    if (tx_log.size() >= off + 4) begin
      check("t2_byte0", tx_log[off + 0], 8'h91);
      check("t2_byte1", tx_log[off + 1], 8'h22);
      check("t2_byte2", tx_log[off + 2], 8'h91);
      check("t2_byte3", tx_log[off + 3], 8'h22);
    end
    if (WAKE && tx_log.size() >= 1) check("t2_wake_first", tx_log[0], 8'h8A);

    // TX backpressure for 10 cycles: byte held stable, taken when released
    tx_log.delete();
    bus.tx_busy = 1'b1;
    send_dbg(7'h5A);
    repeat (10) tick();
    check("t3_stb_held", bus.tx_stb, 1'b1);
    check("t3_data_held", bus.tx_data, 8'hDA);
    check("t3_none_sent", tx_log.size(), 0);
    bus.tx_busy = 1'b0;
    tick();
    check("t3_sent_once", tx_log.size(), 1);
    if (tx_log.size() == 1) check("t3_sent_byte", tx_log[0], 8'hDA);
    check("t3_stb_cleared", bus.tx_stb, 1'b0);

    // RX demux 41, C2, 43
    dbg_log.delete(); con_log.delete();
    rx_byte(8'h41);
    check("t4_con_stb", bus.rx_con_stb, 1'b1);
    check("t4_con_data0", bus.rx_con_data, 7'h41);
    rx_byte(8'hC2);
    check("t4_dbg_stb", bus.rx_dbg_stb, 1'b1);
    check("t4_dbg_data", bus.rx_dbg_data, 7'h42);
    rx_byte(8'h43);
    check("t4_con_data1", bus.rx_con_data, 7'h43);
    repeat (3) tick();
    check("t4_con_count", con_log.size(), 2);
    check("t4_dbg_count", dbg_log.size(), 1);
    if (con_log.size() == 2) check("t4_con_order", {con_log[0], con_log[1]}, {7'h41, 7'h43});
    if (dbg_log.size() == 1) check("t4_dbg_byte", dbg_log[0], 7'h42);

    // Debug FIFO overflow: 17 bytes into a stalled sink
    dbg_log.delete();
    bus.rx_dbg_busy = 1'b1;
    for (int i = 0; i < 17; i++) rx_byte(8'h80 | 8'(i));
    tick();
    check("t5_dbg_ovfl", bus.dbg_ovfl, 1'b1);
    check("t5_con_ovfl", bus.con_ovfl, 1'b0);
    bus.rx_dbg_busy = 1'b0;
    repeat (20) tick();
    check("t5_drain_count", dbg_log.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < dbg_log.size()) check("t5_drain_data", dbg_log[i], 7'(i));
    check("t5_ovfl_sticky", bus.dbg_ovfl, 1'b1);

    // Randomized traffic with occasional mid-operation reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!bus.tx_dbg_stb || dbg_acc) begin
        bus.tx_dbg_stb = ($urandom_range(0, 1) == 1);
        bus.tx_dbg_data = 7'($urandom_range(0, 127));
      end
      if (!bus.tx_con_stb || con_acc) begin
        bus.tx_con_stb = ($urandom_range(0, 1) == 1);
        bus.tx_con_data = 7'($urandom_range(0, 127));
      end
      bus.tx_busy = ($urandom_range(0, 2) == 0);
      bus.rx_stb = ($urandom_range(0, 2) != 0);
      bus.rx_data = 8'($urandom_range(0, 255));
      bus.rx_dbg_busy = (c < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.rx_con_busy = (c < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    bus.rx_stb = 1'b0; bus.tx_dbg_stb = 1'b0; bus.tx_con_stb = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
